// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin arbiter for BRAM port 0 with read-modify-write mask emulation
module bram_port_arbiter #(
   parameter int NREQ   = 4,
   parameter int AW     = 9,
   parameter int DW     = 32,
   parameter bit RMW_EN = 1'b1
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic [NREQ-1:0]    REQ_VALID,
   output logic [NREQ-1:0]    REQ_READY,
   input  logic [NREQ-1:0]    REQ_WE,
   input  logic [NREQ*AW-1:0] REQ_ADDR,
   input  logic [NREQ*DW-1:0] REQ_WDATA,
   input  logic [NREQ*DW-1:0] REQ_WMASK,
   output logic [NREQ-1:0]    RSP_VALID,
   output logic [DW-1:0]      RSP_RDATA,
   output logic [AW-1:0]      MEM_A,
   output logic [DW-1:0]      MEM_D,
   output logic               MEM_WE,
   output logic               MEM_CE,
   input  logic [DW-1:0]      MEM_Q
);
   localparam int PW = $clog2(NREQ);
   localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

   typedef enum logic {IDLE, RMW_WR} state_t;

   state_t         state;
   logic [PW-1:0]  ptr;
   logic           rsp_pend;
   logic           rsp_read;
   logic [PW-1:0]  rsp_owner;
   logic [PW-1:0]  rmw_owner;
   logic [AW-1:0]  rmw_addr;
   logic [DW-1:0]  rmw_wdata;
   logic [DW-1:0]  rmw_mask;

   logic           grant_any;
   logic [PW-1:0]  grant_idx;
   logic [PW:0]    cand;
   logic [PW:0]    ptr_inc;
   logic [PW-1:0]  ptr_next;
   logic           sel_we;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_wdata;
   logic [DW-1:0]  sel_mask;
   logic           mask_full;
   logic           mask_zero;
   logic           is_rmw;
   logic           is_skip;

   // Scan downward in offset so the last hit is the closest requester at or above ptr.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (PW+1)'(i);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (REQ_VALID[cand[PW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_mask  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == PW'(i)) begin
            sel_we    = REQ_WE[i];
            sel_addr  = REQ_ADDR[i*AW +: AW];
            sel_wdata = REQ_WDATA[i*DW +: DW];
            sel_mask  = REQ_WMASK[i*DW +: DW];
         end
      end
   end

   assign mask_full = &sel_mask;
   assign mask_zero = ~|sel_mask;
   assign is_rmw    = grant_any && sel_we && RMW_EN && !mask_full && !mask_zero;
   assign is_skip   = grant_any && sel_we && RMW_EN && mask_zero;
   assign ptr_inc   = {1'b0, grant_idx} + (PW+1)'(1);
   assign ptr_next  = (ptr_inc == NREQ_W) ? '0 : ptr_inc[PW-1:0];

   // Everything is gated by RSTN so a held reset silences the BRAM and requesters immediately.
   always_comb begin
      REQ_READY = '0;
      MEM_CE    = 1'b0;
      MEM_WE    = 1'b0;
      MEM_A     = '0;
      MEM_D     = '0;
      RSP_VALID = '0;
      RSP_RDATA = '0;
      if (RSTN) begin
         if (state == RMW_WR) begin
            MEM_CE = 1'b1;
            MEM_WE = 1'b1;
            MEM_A  = rmw_addr;
            MEM_D  = (MEM_Q & ~rmw_mask) | (rmw_wdata & rmw_mask);
         end else if (grant_any) begin
            REQ_READY[grant_idx] = 1'b1;
            if (!is_skip) begin
               MEM_CE = 1'b1;
               MEM_A  = sel_addr;
            end
            if (sel_we && !is_rmw && !is_skip) begin
               MEM_WE = 1'b1;
               MEM_D  = sel_wdata;
            end
         end
         if (rsp_pend) begin
            RSP_VALID[rsp_owner] = 1'b1;
            if (rsp_read) begin
               RSP_RDATA = MEM_Q;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state     <= IDLE;
         ptr       <= '0;
         rsp_pend  <= 1'b0;
         rsp_read  <= 1'b0;
         rsp_owner <= '0;
         rmw_owner <= '0;
         rmw_addr  <= '0;
         rmw_wdata <= '0;
         rmw_mask  <= '0;
      end else begin
         rsp_pend <= 1'b0;
         rsp_read <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  ptr <= ptr_next;
                  if (is_rmw) begin
                     state     <= RMW_WR;
                     rmw_owner <= grant_idx;
                     rmw_addr  <= sel_addr;
                     rmw_wdata <= sel_wdata;
                     rmw_mask  <= sel_mask;
                  end else begin
                     rsp_pend  <= 1'b1;
                     rsp_owner <= grant_idx;
                     rsp_read  <= !sel_we;
                  end
               end
            end
            RMW_WR: begin
               state     <= IDLE;
               rsp_pend  <= 1'b1;
               rsp_owner <= rmw_owner;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - randomized self-checking bench with a transaction-level reference model
module tb_bram_port_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 9;
   localparam int DW   = 32;

   logic               clk = 1'b0;
   logic               rstn;
   logic [NREQ-1:0]    req_valid, req_ready, req_we, rsp_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata, req_wmask;
   logic [DW-1:0]      rsp_rdata, mem_d, mem_q;
   logic [AW-1:0]      mem_a;
   logic               mem_we, mem_ce;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [DW-1:0] bram    [0:511];
   logic [DW-1:0] ref_mem [0:511];

   typedef struct packed {
      int          due;
      int          owner;
      logic [31:0] data;
   } rsp_t;
   rsp_t rsp_q[$];

   always #5 clk = ~clk;

   bram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RMW_EN(1'b1)) dut (
      .CLK(clk), .RSTN(rstn),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
      .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_WMASK(req_wmask),
      .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
      .MEM_A(mem_a), .MEM_D(mem_d), .MEM_WE(mem_we), .MEM_CE(mem_ce), .MEM_Q(mem_q)
   );

   function automatic logic [31:0] init_word(input int i);
      case (i)
         5:       return 32'hDEAD_BEEF;
         16:      return 32'h1234_5678;
         32:      return 32'h5A5A_5A5A;
         48:      return 32'h0F0F_0F0F;
         511:     return 32'h0000_0000;
         default: return (32'(i) * 32'h0100_0193) ^ 32'hC3A5_1E00;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Synchronous single-port BRAM behind port 0.
   initial begin
      mem_q <= '0;
      for (int i = 0; i < 512; i++) bram[i] <= init_word(i);
      forever begin
         @(posedge clk);
         if (mem_ce) begin
            if (mem_we) bram[mem_a] <= mem_d;
            else        mem_q <= bram[mem_a];
         end
      end
   end

   // Reference model: per-cycle expected outputs from arbitration rules, a shadow memory
   // updated when writes commit, and a queue of responses with their due cycle.
   initial begin : model
      logic [NREQ-1:0] e_ready, e_rv;
      logic            e_ce, e_we, we, rsp_due, m_busy;
      logic [AW-1:0]   e_a, a, m_addr;
      logic [DW-1:0]   e_d, e_rd, wd, mk, m_wdata, m_mask;
      int              g, m_ptr, m_owner;
      m_busy = 1'b0; m_ptr = 0; m_owner = 0;
      m_addr = '0; m_wdata = '0; m_mask = '0;
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
      forever begin
         @(negedge clk);
         e_ready = '0; e_rv = '0; e_ce = 1'b0; e_we = 1'b0;
         e_a = '0; e_d = '0; e_rd = '0; g = -1;
         we = 1'b0; a = '0; wd = '0; mk = '0;
         rsp_due = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
         if (rstn) begin
            if (m_busy) begin
               e_ce = 1'b1; e_we = 1'b1; e_a = m_addr;
               e_d  = (ref_mem[m_addr] & ~m_mask) | (m_wdata & m_mask);
            end else begin
               for (int k = 0; k < NREQ; k++)
                  if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
               if (g >= 0) begin
                  e_ready[g] = 1'b1;
                  we = req_we[g];
                  a  = req_addr[g*AW +: AW];
                  wd = req_wdata[g*DW +: DW];
                  mk = req_wmask[g*DW +: DW];
                  if (!we) begin
                     e_ce = 1'b1; e_a = a;
                  end else if (mk == '1) begin
                     e_ce = 1'b1; e_we = 1'b1; e_a = a; e_d = wd;
                  end else if (mk != '0) begin
                     e_ce = 1'b1; e_a = a;
                  end
               end
            end
            if (rsp_due) begin
               e_rv[rsp_q[0].owner] = 1'b1;
               e_rd = rsp_q[0].data;
            end
         end
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("mem_ce", 32'(mem_ce), 32'(e_ce));
         chk("mem_we", 32'(mem_we), 32'(e_we));
         if (e_ce || !rstn) chk("mem_a", 32'(mem_a), 32'(e_a));
         if (e_we || !rstn) chk("mem_d", mem_d, e_d);
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         if (e_rv != '0 || !rstn) chk("rsp_rdata", rsp_rdata, e_rd);

         if (!rstn) begin
            m_busy = 1'b0; m_ptr = 0;
            rsp_q.delete();
         end else begin
            if (rsp_due) void'(rsp_q.pop_front());
            if (m_busy) begin
               ref_mem[m_addr] = e_d;
               rsp_q.push_back('{due: cyc + 1, owner: m_owner, data: 32'h0});
               m_busy = 1'b0;
            end else if (g >= 0) begin
               m_ptr = (g + 1) % NREQ;
               if (!we) begin
                  rsp_q.push_back('{due: cyc + 1, owner: g, data: ref_mem[a]});
               end else if (mk == '1) begin
                  ref_mem[a] = wd;
                  rsp_q.push_back('{due: cyc + 1, owner: g, data: 32'h0});
               end else if (mk == '0) begin
                  rsp_q.push_back('{due: cyc + 1, owner: g, data: 32'h0});
               end else begin
                  m_busy = 1'b1; m_addr = a; m_wdata = wd; m_mask = mk; m_owner = g;
               end
            end
         end
         cyc++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] mk);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = wd;
      req_wmask[i*DW +: DW] = mk;
   endtask

   initial begin : stim
      int cnt [NREQ];
      rstn = 1'b0;
      clear_reqs();
      req_valid = '1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_ready", 32'(req_ready), 32'h0);
      chk("reset_ce", 32'(mem_ce), 32'h0);
      tick();
      clear_reqs();
      rstn = 1'b1;
      tick();

      // single read
      set_req(0, 1'b0, 9'h005, '0, '0);
      @(negedge clk);
      chk("rd_ready", 32'(req_ready), 32'h1);
      chk("rd_ce", 32'(mem_ce), 32'h1);
      tick();
      clear_reqs();
      @(negedge clk);
      chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("rd_rsp_data", rsp_rdata, 32'hDEAD_BEEF);
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;

      // fairness
      for (int i = 0; i < NREQ; i++) begin
         cnt[i] = 0;
         set_req(i, 1'b0, 9'(i * 3 + 1), '0, '0);
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("fair_grant", 32'(req_ready), 32'(1) << (k % NREQ));
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
         tick();
      end
      clear_reqs();
      for (int i = 0; i < NREQ; i++) chk("fair_count", 32'(cnt[i]), 32'd4);

      // partial write via read-modify-write
      set_req(1, 1'b1, 9'h010, 32'hAABB_CCDD, 32'h0000_FFFF);
      @(negedge clk);
      chk("rmw_accept_ready", 32'(req_ready), 32'h2);
      chk("rmw_accept_we", 32'(mem_we), 32'h0);
      tick();
      clear_reqs();
      set_req(0, 1'b0, 9'h003, '0, '0);
      @(negedge clk);
      chk("rmw_ready_blocked", 32'(req_ready), 32'h0);
      chk("rmw_wr_we", 32'(mem_we), 32'h1);
      chk("rmw_wr_a", 32'(mem_a), 32'h010);
      chk("rmw_wr_d", mem_d, 32'h1234_CCDD);
      tick();
      clear_reqs();
      @(negedge clk);
      chk("rmw_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("rmw_rsp_data", rsp_rdata, 32'h0);
      chk("rmw_mem", bram[16], 32'h1234_CCDD);
      tick();

      // full write then read of the same word
      set_req(2, 1'b1, 9'h1FF, 32'h0000_0001, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("fw_ready", 32'(req_ready), 32'h4);
      tick();
      clear_reqs();
      set_req(3, 1'b0, 9'h1FF, '0, '0);
      @(negedge clk);
      chk("raw_ready", 32'(req_ready), 32'h8);
      tick();
      clear_reqs();
      @(negedge clk);
      chk("raw_rsp_valid", 32'(rsp_valid), 32'h8);
      chk("raw_rsp_data", rsp_rdata, 32'h0000_0001);
      tick();

      // zero mask write
      set_req(0, 1'b1, 9'h020, 32'hFFFF_FFFF, 32'h0);
      @(negedge clk);
      chk("zm_ready", 32'(req_ready), 32'h1);
      chk("zm_ce", 32'(mem_ce), 32'h0);
      tick();
      clear_reqs();
      @(negedge clk);
      chk("zm_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("zm_rsp_data", rsp_rdata, 32'h0);
      chk("zm_mem", bram[32], 32'h5A5A_5A5A);
      tick();

      // reset in the RMW_WR cycle
      set_req(1, 1'b1, 9'h030, 32'hFFFF_0000, 32'h00FF_00FF);
      @(negedge clk);
      chk("rst_accept_ready", 32'(req_ready), 32'h2);
      tick();
      clear_reqs();
      rstn = 1'b0;
      @(negedge clk);
      chk("rst_rmw_we", 32'(mem_we), 32'h0);
      tick();
      rstn = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 9'h040, '0, '0);
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
      chk("rst_ptr", 32'(req_ready), 32'h1);
      tick();
      clear_reqs();
      tick();
      chk("rst_mem", bram[48], 32'h0F0F_0F0F);

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         clear_reqs();
         rstn = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            logic [31:0] mk;
            logic [8:0]  ad;
            if ($urandom_range(0, 9) < 6) begin
               case ($urandom_range(0, 3))
                  0:       mk = 32'hFFFF_FFFF;
                  1:       mk = 32'h0;
                  default: mk = $urandom;
               endcase
               ad = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
               set_req(i, 1'($urandom_range(0, 1)), ad, $urandom, mk);
            end
         end
         tick();
      end
      rstn = 1'b1;
      clear_reqs();
      repeat (4) tick();
      for (int i = 0; i < 512; i++) chk("mem_final", bram[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
